// File: rtl/fetch_seq_pkg.sv
// Shared control encodings for the fetch sequencer: FSM states, next-PC opcodes, reset PC.
package fetch_seq_pkg;

  localparam logic [31:0] ResetPcDefault = 32'h0000_3000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } fetch_state_e;

  // Next-PC opcodes chosen by the redirect tracker each cycle
  typedef enum logic [1:0] {
    NpcKeep  = 2'd0,
    NpcSeq   = 2'd1,
    NpcRedir = 2'd2
  } npc_op_e;

endpackage

// File: rtl/fetch_seq_redir_track.sv
// Tracks one pending redirect: delay-slot match address, squash decision and sticky error.
module fetch_seq_redir_track
  import fetch_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redir_valid_i,
  input  logic [31:0] redir_src_i,
  input  logic [31:0] redir_target_i,
  input  logic [31:0] pc_i,
  input  logic        in_req_i,
  input  logic        fire_i,
  output npc_op_e     npc_op_o,
  output logic        squash_o,
  output logic [31:0] target_o,
  output logic        seq_err_o
);

  logic        pend_q, pend_d;
  logic        squash_q, squash_d;
  logic [31:0] match_q, match_d;
  logic [31:0] target_q, target_d;
  logic        seq_err_q, seq_err_d;

  logic        capture, late_hit, eff_valid, eff_squash;
  logic [31:0] tgt_in, slot_addr, late_addr, eff_match, eff_target;

  // A redirect arriving this cycle is judged against the current pc, before any increment
  always_comb begin
    capture    = redir_valid_i & ~pend_q;
    tgt_in     = {redir_target_i[31:2], 2'b00};
    slot_addr  = redir_src_i + 32'd4;
    late_addr  = redir_src_i + 32'd8;
    late_hit   = capture & (pc_i == late_addr);
    eff_valid  = pend_q | capture;
    eff_match  = pend_q ? match_q : (late_hit ? late_addr : slot_addr);
    eff_squash = pend_q ? squash_q : late_hit;
    eff_target = pend_q ? target_q : tgt_in;

    pend_d    = pend_q;
    squash_d  = squash_q;
    match_d   = match_q;
    target_d  = target_q;
    seq_err_d = seq_err_q | (redir_valid_i & pend_q);
    npc_op_o  = fire_i ? NpcSeq : NpcKeep;
    squash_o  = 1'b0;
    target_o  = eff_target;

    if (late_hit && !in_req_i) begin
      // Delay slot already fetched but the next fetch not yet requested: jump now
      npc_op_o = NpcRedir;
    end else if (fire_i && eff_valid && (pc_i == eff_match)) begin
      npc_op_o = NpcRedir;
      squash_o = eff_squash;
      pend_d   = 1'b0;
    end else if (capture) begin
      pend_d   = 1'b1;
      squash_d = late_hit;
      match_d  = eff_match;
      target_d = tgt_in;
    end
  end

  // Pending-redirect and error registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_q    <= 1'b0;
      squash_q  <= 1'b0;
      match_q   <= 32'd0;
      target_q  <= 32'd0;
      seq_err_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      squash_q  <= squash_d;
      match_q   <= match_d;
      target_q  <= target_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err_o = seq_err_q;

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: issues word fetches, holds under decode stall, applies
// delayed-branch redirects. All outputs come straight from registers.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] ResetPc = ResetPcDefault
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        redir_valid_i,
  input  logic [31:0] redir_src_i,
  input  logic [31:0] redir_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic        seq_err_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_pc_q, if_pc_d;

  logic         fire;
  logic         squash;
  npc_op_e      npc_op;
  logic [31:0]  redir_tgt;

  assign fire = (state_q == StReq) & imem_ack_i;

  fetch_seq_redir_track u_redir_track (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .redir_valid_i  (redir_valid_i),
    .redir_src_i    (redir_src_i),
    .redir_target_i (redir_target_i),
    .pc_i           (pc_q),
    .in_req_i       (state_q == StReq),
    .fire_i         (fire),
    .npc_op_o       (npc_op),
    .squash_o       (squash),
    .target_o       (redir_tgt),
    .seq_err_o      (seq_err_o)
  );

  // Next state, fetch PC and decode-facing instruction register
  always_comb begin
    state_d    = state_q;
    if_pc_d    = if_pc_q;
    // A presented instruction retires when decode is not stalling
    if_valid_d = if_valid_q & stall_i;

    case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (imem_ack_i && !squash) begin
          if_valid_d = 1'b1;
          if_pc_d    = pc_q;
          state_d    = stall_i ? StHold : StReq;
        end
      end
      StHold: begin
        if (!stall_i) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase

    case (npc_op)
      NpcSeq:   pc_d = pc_q + 32'd4;
      NpcRedir: pc_d = redir_tgt;
      default:  pc_d = pc_q;
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      pc_q       <= ResetPc;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign imem_req_o  = (state_q == StReq);
  assign imem_addr_o = pc_q;
  assign if_valid_o  = if_valid_q;
  assign if_pc_o     = if_pc_q;

endmodule
